// File: rtl/adxl345_access_scheduler.sv
// Arbitrates host register accesses and interrupt-driven sample reads onto one I2C master port.
// Optional status counters are built when ADXL_SCHED_STATUS_EN is defined; otherwise they read as zero.
module adxl345_access_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  INT_SOURCE_PTR = 8'h30,
  parameter logic [7:0]  DATA_PTR       = 8'h32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        h_req,
  input  logic        h_rw,
  input  logic [7:0]  h_ptr,
  input  logic [7:0]  h_len,
  input  logic [7:0]  h_wdata,
  output logic        h_gnt,
  output logic [7:0]  h_rdata,
  output logic        h_rvalid,
  output logic        h_done,
  output logic        h_err,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic        m_cmd_rw,
  output logic [7:0]  m_cmd_ptr,
  output logic [7:0]  m_cmd_len,
  output logic [7:0]  m_cmd_wdata,
  input  logic [7:0]  m_rd_data,
  input  logic        m_rd_valid,
  input  logic        m_done,
  input  logic        m_err,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic [31:0] irq_count,
  output logic [15:0] err_count,
  output logic [2:0]  dbg_state
);

  // Command handshake: the payload is presented with m_cmd_valid and held unchanged
  // until the cycle in which m_cmd_valid && m_cmd_ready, which is the single transfer cycle.
  typedef enum logic [2:0] {
    IDLE, HOST_CMD, HOST_WAIT, SRC_CMD, SRC_WAIT, DATA_CMD, DATA_WAIT, SAMPLE_OUT
  } state_t;

  state_t      state, state_next;
  logic        irq_s1, irq_s2;
  logic [1:0]  req_age;
  logic        host_starved;
  logic        rw_q;
  logic [7:0]  ptr_q, len_q, wdata_q;
  logic [7:0]  cnt;
  logic [31:0] tmo_cnt;
  logic [7:0]  rx_buf [6];
  logic [7:0]  buf_eff [6];

  logic        host_pend, in_wait, byte_take, timeout, fail;
  logic        grant_host, grant_irq, sample_load;
  logic [7:0]  exp_len, cnt_eff;

  // A host request is only considered once it has been held as long as the irq
  // synchroniser delay, so simultaneous arrivals meet in the arbiter on the same cycle.
  assign host_pend = h_req & req_age[1];
  assign in_wait   = (state == HOST_WAIT) || (state == SRC_WAIT) || (state == DATA_WAIT);

  always_comb begin
    exp_len = 8'd0;
    case (state)
      HOST_WAIT: exp_len = rw_q ? len_q : 8'd0;
      SRC_WAIT:  exp_len = 8'd1;
      DATA_WAIT: exp_len = 8'd6;
      default:   exp_len = 8'd0;
    endcase
  end

  assign byte_take = in_wait & m_rd_valid & (cnt < exp_len);
  assign cnt_eff   = cnt + {7'd0, byte_take};
  assign timeout   = in_wait && (tmo_cnt >= TIMEOUT_CYCLES - 1);
  assign fail      = in_wait && ((m_done && (m_err || (cnt_eff != exp_len))) || (!m_done && timeout));
  assign h_rdata   = m_rd_data;
  assign dbg_state = state;

  always_comb begin
    for (int i = 0; i < 6; i++) buf_eff[i] = rx_buf[i];
    if (byte_take && (state != HOST_WAIT)) buf_eff[cnt[2:0]] = m_rd_data;
  end

  always_comb begin
    state_next   = state;
    h_gnt        = 1'b0;
    h_rvalid     = 1'b0;
    h_done       = 1'b0;
    h_err        = 1'b0;
    m_cmd_valid  = 1'b0;
    m_cmd_rw     = 1'b0;
    m_cmd_ptr    = 8'd0;
    m_cmd_len    = 8'd0;
    m_cmd_wdata  = 8'd0;
    sample_valid = 1'b0;
    grant_host   = 1'b0;
    grant_irq    = 1'b0;
    sample_load  = 1'b0;
    case (state)
      IDLE: begin
        if (irq_s2 && !(host_pend && host_starved)) begin
          grant_irq  = 1'b1;
          state_next = SRC_CMD;
        end else if (host_pend) begin
          grant_host = 1'b1;
          h_gnt      = 1'b1;
          if (h_len == 8'd0) begin
            h_done = 1'b1;
            h_err  = 1'b1;
          end else begin
            state_next = HOST_CMD;
          end
        end
      end
      HOST_CMD: begin
        m_cmd_valid = 1'b1;
        m_cmd_rw    = rw_q;
        m_cmd_ptr   = ptr_q;
        m_cmd_len   = len_q;
        m_cmd_wdata = wdata_q;
        if (m_cmd_ready) state_next = HOST_WAIT;
      end
      HOST_WAIT: begin
        h_rvalid = byte_take;
        if (fail || m_done) begin
          h_done     = 1'b1;
          h_err      = fail;
          state_next = IDLE;
        end
      end
      SRC_CMD: begin
        m_cmd_valid = 1'b1;
        m_cmd_rw    = 1'b1;
        m_cmd_ptr   = INT_SOURCE_PTR;
        m_cmd_len   = 8'd1;
        if (m_cmd_ready) state_next = SRC_WAIT;
      end
      SRC_WAIT: begin
        if (fail) state_next = IDLE;
        else if (m_done) state_next = buf_eff[0][7] ? DATA_CMD : IDLE;
      end
      DATA_CMD: begin
        m_cmd_valid = 1'b1;
        m_cmd_rw    = 1'b1;
        m_cmd_ptr   = DATA_PTR;
        m_cmd_len   = 8'd6;
        if (m_cmd_ready) state_next = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (fail) begin
          state_next = IDLE;
        end else if (m_done) begin
          sample_load = 1'b1;
          state_next  = SAMPLE_OUT;
        end
      end
      SAMPLE_OUT: begin
        sample_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      state_next   = IDLE;
      h_gnt        = 1'b0;
      h_rvalid     = 1'b0;
      h_done       = 1'b0;
      h_err        = 1'b0;
      m_cmd_valid  = 1'b0;
      sample_valid = 1'b0;
      grant_host   = 1'b0;
      grant_irq    = 1'b0;
      sample_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      irq_s1       <= 1'b0;
      irq_s2       <= 1'b0;
      req_age      <= 2'b00;
      host_starved <= 1'b0;
      rw_q         <= 1'b0;
      ptr_q        <= 8'd0;
      len_q        <= 8'd0;
      wdata_q      <= 8'd0;
      cnt          <= 8'd0;
      tmo_cnt      <= 32'd0;
      sample_x     <= 16'd0;
      sample_y     <= 16'd0;
      sample_z     <= 16'd0;
      for (int i = 0; i < 6; i++) rx_buf[i] <= 8'd0;
    end else begin
      state  <= state_next;
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
      if (!h_req || h_gnt) req_age <= 2'b00;
      else req_age <= {req_age[0], 1'b1};
      if (grant_host) host_starved <= 1'b0;
      else if (grant_irq && host_pend) host_starved <= 1'b1;
      if (grant_host) begin
        rw_q    <= h_rw;
        ptr_q   <= h_ptr;
        len_q   <= h_len;
        wdata_q <= h_wdata;
      end
      if (!in_wait) cnt <= 8'd0;
      else if (byte_take) cnt <= cnt + 8'd1;
      if (!in_wait || m_rd_valid) tmo_cnt <= 32'd0;
      else tmo_cnt <= tmo_cnt + 32'd1;
      for (int i = 0; i < 6; i++) rx_buf[i] <= buf_eff[i];
      if (sample_load) begin
        sample_x <= {buf_eff[1], buf_eff[0]};
        sample_y <= {buf_eff[3], buf_eff[2]};
        sample_z <= {buf_eff[5], buf_eff[4]};
      end
    end
  end

`ifdef ADXL_SCHED_STATUS_EN
  logic [31:0] irq_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_cnt_q <= 32'd0;
      err_cnt_q <= 16'd0;
    end else begin
      if ((state == SAMPLE_OUT) && (irq_cnt_q != 32'hFFFF_FFFF)) irq_cnt_q <= irq_cnt_q + 32'd1;
      if (fail && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign irq_count = irq_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign irq_count = 32'd0;
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_adxl345_access_scheduler.sv
// Directed bench for adxl345_access_scheduler: sample reads, arbitration, host paths, aborts and reset.
module tb_adxl345_access_scheduler;
  localparam int TMO = 40;
`ifdef ADXL_SCHED_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq = 1'b0;
  logic        h_req = 1'b0, h_rw = 1'b0;
  logic [7:0]  h_ptr = 8'd0, h_len = 8'd0, h_wdata = 8'd0;
  logic        h_gnt, h_rvalid, h_done, h_err;
  logic [7:0]  h_rdata;
  logic        m_cmd_valid, m_cmd_rw;
  logic        m_cmd_ready = 1'b0;
  logic [7:0]  m_cmd_ptr, m_cmd_len, m_cmd_wdata;
  logic [7:0]  m_rd_data = 8'd0;
  logic        m_rd_valid = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic [31:0] irq_count;
  logic [15:0] err_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int sv_cnt = 0, gnt_cnt = 0, done_cnt = 0, herr_cnt = 0, cmd_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  adxl345_access_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .h_req(h_req), .h_rw(h_rw), .h_ptr(h_ptr), .h_len(h_len), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_done(h_done), .h_err(h_err),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_rw(m_cmd_rw),
    .m_cmd_ptr(m_cmd_ptr), .m_cmd_len(m_cmd_len), .m_cmd_wdata(m_cmd_wdata),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_done(m_done), .m_err(m_err),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z), .sample_valid(sample_valid),
    .irq_count(irq_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock / monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_valid) sv_cnt++;
    if (h_gnt) gnt_cnt++;
    if (h_done) done_cnt++;
    if (h_done && h_err) herr_cnt++;
    if (m_cmd_valid && m_cmd_ready) cmd_cnt++;
    if (h_rvalid) got_q.push_back(h_rdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Master driver tasks
  task automatic serve_cmd(input string tag, input logic erw, input logic [7:0] eptr,
                           input logic [7:0] elen, input logic [7:0] ewd, input int hold);
    int t = 0;
    while (!m_cmd_valid && t < 50) begin cyc(); t++; end
    check({tag, "_valid"}, {31'd0, m_cmd_valid}, 32'd1);
    repeat (hold) cyc();
    check({tag, "_rw"}, {31'd0, m_cmd_rw}, {31'd0, erw});
    check({tag, "_ptr"}, {24'd0, m_cmd_ptr}, {24'd0, eptr});
    check({tag, "_len"}, {24'd0, m_cmd_len}, {24'd0, elen});
    if (!erw) check({tag, "_wdata"}, {24'd0, m_cmd_wdata}, {24'd0, ewd});
    m_cmd_ready = 1'b1;
    cyc();
    m_cmd_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    m_rd_valid = 1'b1;
    m_rd_data  = b;
    cyc();
    m_rd_valid = 1'b0;
  endtask

  task automatic finish_xfer(input logic e);
    m_done = 1'b1;
    m_err  = e;
    cyc();
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  initial begin
    int t;
    int c0, s0, d0, e0;
    // Reset
    repeat (3) cyc();
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_cmd_valid", {31'd0, m_cmd_valid}, 32'd0);
    check("rst_sample_x", {16'd0, sample_x}, 32'd0);
    check("rst_sample_z", {16'd0, sample_z}, 32'd0);
    check("rst_irq_count", irq_count, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    reset = 1'b1;
    cyc();

    // Full sample read
    irq = 1'b1;
    serve_cmd("s1_src", 1'b1, 8'h30, 8'd1, 8'd0, 0);
    irq = 1'b0;
    send_byte(8'h80);
    finish_xfer(1'b0);
    serve_cmd("s1_data", 1'b1, 8'h32, 8'd6, 8'd0, 0);
    for (int i = 1; i <= 6; i++) send_byte(i[7:0]);
    finish_xfer(1'b0);
    repeat (4) cyc();
    check("s1_x", {16'd0, sample_x}, 32'h0201);
    check("s1_y", {16'd0, sample_y}, 32'h0403);
    check("s1_z", {16'd0, sample_z}, 32'h0605);
    check("s1_valid_pulses", sv_cnt, 1);
    check("s1_irq_count", irq_count, STAT ? 32'd1 : 32'd0);
    check("s1_idle", {29'd0, dbg_state}, 32'd0);

    // Interrupt source without DATA_READY
    c0 = cmd_cnt;
    irq = 1'b1;
    serve_cmd("s2_src", 1'b1, 8'h30, 8'd1, 8'd0, 0);
    irq = 1'b0;
    send_byte(8'h00);
    finish_xfer(1'b0);
    repeat (6) cyc();
    check("s2_one_cmd", cmd_cnt - c0, 1);
    check("s2_no_sample", sv_cnt, 1);
    check("s2_idle", {29'd0, dbg_state}, 32'd0);

    // Simultaneous irq and host read; irq stays high so host must win the next round
    irq = 1'b1;
    h_req = 1'b1; h_rw = 1'b1; h_ptr = 8'h00; h_len = 8'd1;
    serve_cmd("s3_src1", 1'b1, 8'h30, 8'd1, 8'd0, 0);
    send_byte(8'h00);
    finish_xfer(1'b0);
    serve_cmd("s3_host", 1'b1, 8'h00, 8'd1, 8'd0, 0);
    h_req = 1'b0;
    exp_q.push_back(8'hE5);
    send_byte(8'hE5);
    send_byte(8'h77);
    finish_xfer(1'b0);
    serve_cmd("s3_src2", 1'b1, 8'h30, 8'd1, 8'd0, 0);
    irq = 1'b0;
    send_byte(8'h00);
    finish_xfer(1'b0);
    repeat (4) cyc();
    check("s3_gnt", gnt_cnt, 1);
    check("s3_done", done_cnt, 1);
    check("s3_herr", herr_cnt, 0);
    check("s3_rbytes", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("s3_rdata", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});

    // Zero-length host request
    c0 = cmd_cnt;
    h_req = 1'b1; h_rw = 1'b1; h_ptr = 8'h00; h_len = 8'd0;
    t = 0;
    while (!h_gnt && t < 20) begin cyc(); t++; end
    cyc();
    h_req = 1'b0;
    repeat (3) cyc();
    check("s4_gnt", gnt_cnt, 2);
    check("s4_done", done_cnt, 2);
    check("s4_herr", herr_cnt, 1);
    check("s4_no_cmd", cmd_cnt - c0, 0);

    // Host write
    h_req = 1'b1; h_rw = 1'b0; h_ptr = 8'h2D; h_len = 8'd1; h_wdata = 8'h08;
    serve_cmd("s5_wr", 1'b0, 8'h2D, 8'd1, 8'h08, 0);
    h_req = 1'b0;
    finish_xfer(1'b0);
    repeat (2) cyc();
    check("s5_done", done_cnt, 3);
    check("s5_herr", herr_cnt, 1);

    // Short data read aborts
    irq = 1'b1;
    serve_cmd("s6_src", 1'b1, 8'h30, 8'd1, 8'd0, 0);
    irq = 1'b0;
    send_byte(8'h80);
    finish_xfer(1'b0);
    serve_cmd("s6_data", 1'b1, 8'h32, 8'd6, 8'd0, 0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    finish_xfer(1'b0);
    repeat (4) cyc();
    check("s6_x_kept", {16'd0, sample_x}, 32'h0201);
    check("s6_z_kept", {16'd0, sample_z}, 32'h0605);
    check("s6_no_sample", sv_cnt, 1);
    check("s6_err_count", {16'd0, err_count}, STAT ? 32'd1 : 32'd0);
    check("s6_idle", {29'd0, dbg_state}, 32'd0);

    // Host read with slow ready, then a silent master
    h_req = 1'b1; h_rw = 1'b1; h_ptr = 8'h00; h_len = 8'd1;
    serve_cmd("s7_host", 1'b1, 8'h00, 8'd1, 8'd0, 60);
    h_req = 1'b0;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < 100) begin cyc(); t++; end
    check("s7_done", done_cnt, d0 + 1);
    check("s7_herr", herr_cnt, 2);
    check("s7_wait_cycles", t, TMO);
    check("s7_err_count", {16'd0, err_count}, STAT ? 32'd2 : 32'd0);

    // Reset during DATA_WAIT, then a stale completion
    irq = 1'b1;
    serve_cmd("s8_src", 1'b1, 8'h30, 8'd1, 8'd0, 0);
    irq = 1'b0;
    send_byte(8'h80);
    finish_xfer(1'b0);
    serve_cmd("s8_data", 1'b1, 8'h32, 8'd6, 8'd0, 0);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b0;
    cyc();
    check("s8_state", {29'd0, dbg_state}, 32'd0);
    check("s8_cmd_valid", {31'd0, m_cmd_valid}, 32'd0);
    check("s8_sample_x", {16'd0, sample_x}, 32'd0);
    check("s8_sample_y", {16'd0, sample_y}, 32'd0);
    check("s8_irq_count", irq_count, 32'd0);
    check("s8_err_count", {16'd0, err_count}, 32'd0);
    reset = 1'b1;
    s0 = sv_cnt; e0 = herr_cnt; d0 = done_cnt; c0 = cmd_cnt;
    send_byte(8'h33);
    finish_xfer(1'b0);
    repeat (3) cyc();
    check("s8_stale_state", {29'd0, dbg_state}, 32'd0);
    check("s8_stale_sample", sv_cnt, s0);
    check("s8_stale_done", done_cnt, d0);
    check("s8_stale_err", herr_cnt, e0);
    check("s8_stale_cmd", cmd_cnt, c0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adxl345_access_scheduler.md
ADXL345_ACCESS_SCHEDULER -- requirements
Module: adxl345_access_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: max cycles in any WAIT state before abort.
REQ-002 Parameter INT_SOURCE_PTR, default 8'h30: interrupt source register address.
REQ-003 Parameter DATA_PTR, default 8'h32: first data register address (6-byte burst, X0..Z1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 irq  in  1  device interrupt, asynchronous, level-high; 2-FF synchronised internally.
REQ-007 h_req/h_rw/h_ptr/h_len/h_wdata  in  1/1/8/8/8  host request, rw=1 read, held until h_gnt.
REQ-008 h_gnt  out  1  one-cycle pulse, host request accepted.
REQ-009 h_rdata/h_rvalid  out  8/1  host read byte stream.
REQ-010 h_done/h_err  out  1/1  one-cycle pulse at host transaction end; err qualifies done.
REQ-011 m_cmd_valid/m_cmd_ready  out/in  1/1  command handshake to I2C master.
REQ-012 m_cmd_rw/m_cmd_ptr/m_cmd_len/m_cmd_wdata  out  1/8/8/8  command payload.
REQ-013 m_rd_data/m_rd_valid  in  8/1  read byte stream from master.
REQ-014 m_done/m_err  in  1/1  master transaction end pulse; m_err = NACK/bus fault.
REQ-015 sample_x/sample_y/sample_z  out  16 each  last accelerometer sample, little-endian assembled.
REQ-016 sample_valid  out  1  one-cycle pulse when all three axes updated.
REQ-017 irq_count/err_count  out  32/16  status counters (see Configuration).

Function
REQ-018 States: IDLE, HOST_CMD, HOST_WAIT, SRC_CMD, SRC_WAIT, DATA_CMD, DATA_WAIT, SAMPLE_OUT.
REQ-019 IDLE, only irq pending: -> SRC_CMD; only h_req: -> HOST_CMD with h_gnt pulse same cycle.
REQ-020 IDLE, both pending: irq wins unless last grant was IRQ service and host waited through it, then host wins (no starvation).
REQ-021 No preemption; irq asserting during a host transaction is serviced after h_done.
REQ-022 *_CMD states: m_cmd_valid=1, payload stable until m_cmd_ready; then -> matching WAIT next cycle.
REQ-023 SRC_CMD payload: rw=1, ptr=INT_SOURCE_PTR, len=1; DATA_CMD: rw=1, ptr=DATA_PTR, len=6.
REQ-024 SRC_WAIT on m_done: bit7 (DATA_READY) of received byte set -> DATA_CMD, else -> IDLE.
REQ-025 DATA_WAIT: byte k (0..5) stored in order; on m_done with 6 bytes -> SAMPLE_OUT.
REQ-026 SAMPLE_OUT: sample_x={b1,b0}, y={b3,b2}, z={b5,b4} updated, sample_valid pulse, -> IDLE; 1 cycle.
REQ-027 HOST_WAIT: m_rd_data forwarded to h_rdata with h_rvalid same cycle (zero latency); on m_done pulse h_done, h_err=m_err.
REQ-028 Host h_len=0: h_gnt and h_done+h_err pulse together, no master command issued, stays IDLE.
REQ-029 Read bytes beyond expected count ignored; m_done before expected count = error.
REQ-030 m_err, short read, or timeout in any WAIT: abort to IDLE, sample not updated, host sees h_err if host-owned.
REQ-031 Timeout counter reset on WAIT entry and on every m_rd_valid.
REQ-032 irq still high on return to IDLE re-triggers service (level-sensitive); minimum 1 IDLE cycle between transactions.

Reset
REQ-033 While reset=0 at clk edge: state IDLE; all pulse outputs, m_cmd_valid, h_gnt 0; sample_* 0; counters 0; synchronisers 0.
REQ-034 Reset mid-transaction drops the command; master completions after reset in IDLE are ignored.

Configuration
REQ-035 Macro ADXL_SCHED_STATUS_EN defined: irq_count increments per SAMPLE_OUT, err_count per REQ-030 abort, both saturating.
REQ-036 Macro undefined: irq_count and err_count tied to 0, counter logic absent; ports remain.

Verification
REQ-037 irq high, INT_SOURCE=8'h80, data 01..06 -> sample_x=16'h0201, y=16'h0403, z=16'h0605, one sample_valid.
REQ-038 irq high, INT_SOURCE=8'h00 -> single 1-byte command, no sample_valid, back to IDLE.
REQ-039 h_req read ptr 8'h00 len 1 with irq rising same cycle -> IRQ served first, then host gets 8'hE5, h_err=0.
REQ-040 m_done after 3 of 6 data bytes -> abort, samples unchanged, err_count+1 with ADXL_SCHED_STATUS_EN.
REQ-041 m_cmd_ready held 0 then master silent TIMEOUT_CYCLES in HOST_WAIT -> h_done with h_err=1.
REQ-042 reset=0 during DATA_WAIT -> next cycle IDLE, m_cmd_valid=0, all outputs at reset values.
